// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate functional unit. It has a valid/ready handshake and a tag passthrough.
// Each stage resolves a contiguous group of the log2(WIDTH) shift levels. A stall freezes the whole chain.
module pipelined_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [2:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_cnt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int LPS   = (CNT_W + STAGES - 1) / STAGES;

  logic              w_stall;
  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [2:0]        r_op   [STAGES];
  logic [CNT_W-1:0]  r_cnt  [STAGES];
  logic [TAG_W-1:0]  r_tag  [STAGES];

  // One power-of-two shift level. Illegal ops pass the data through untouched.
  function automatic logic [WIDTH-1:0] f_level(input logic [WIDTH-1:0] d,
                                               input logic [2:0] op, input int sh);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0, 3'd2: r = d << sh;
      3'd1:       r = d >> sh;
      3'd3:       r = $signed(d) >>> sh;
      3'd4:       r = (d << sh) | (d >> (WIDTH - sh));
      3'd5:       r = (d >> sh) | (d << (WIDTH - sh));
      default:    r = d;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] f_stage(input logic [WIDTH-1:0] d,
                                               input logic [2:0] op,
                                               input logic [CNT_W-1:0] cnt,
                                               input int lo, input int hi);
    logic [WIDTH-1:0] r;
    logic [CNT_W-1:0] bits;
    r = d;
    for (int k = 0; k < CNT_W; k++) begin
      bits = cnt >> k;
      if (k >= lo && k < hi && bits[0]) r = f_level(r, op, 1 << k);
    end
    return r;
  endfunction

  assign out_valid = r_valid[STAGES-1];
  assign w_stall   = out_valid && !out_ready;
  assign in_ready  = !w_stall;
  assign out_data  = r_data[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
  assign out_err   = r_op[STAGES-1][2] & r_op[STAGES-1][1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * LPS;
      localparam int HI = ((gi + 1) * LPS > CNT_W) ? CNT_W : (gi + 1) * LPS;

      logic             w_src_valid;
      logic [WIDTH-1:0] w_src_data;
      logic [2:0]       w_src_op;
      logic [CNT_W-1:0] w_src_cnt;
      logic [TAG_W-1:0] w_src_tag;

      if (gi == 0) begin : g_head
        assign w_src_valid = in_valid;
        assign w_src_data  = in_data;
        assign w_src_op    = in_op;
        assign w_src_cnt   = in_cnt;
        assign w_src_tag   = in_tag;
      end else begin : g_tail
        assign w_src_valid = r_valid[gi-1];
        assign w_src_data  = r_data[gi-1];
        assign w_src_op    = r_op[gi-1];
        assign w_src_cnt   = r_cnt[gi-1];
        assign w_src_tag   = r_tag[gi-1];
      end

      // Bubbles advance like real entries, so latency stays exactly STAGES when unstalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid[gi] <= 1'b0;
          r_data[gi]  <= '0;
          r_op[gi]    <= '0;
          r_cnt[gi]   <= '0;
          r_tag[gi]   <= '0;
        end else if (!w_stall) begin
          r_valid[gi] <= w_src_valid;
          r_data[gi]  <= f_stage(w_src_data, w_src_op, w_src_cnt, LO, HI);
          r_op[gi]    <= w_src_op;
          r_cnt[gi]   <= w_src_cnt;
          r_tag[gi]   <= w_src_tag;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter. It runs directed vectors and randomized traffic on two configurations.
// Expected results come from a queue-based scoreboard and an arithmetic reference of the shift rules.
module tb_pipelined_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_in_op;
  logic [4:0]  a_in_cnt;
  logic [3:0]  a_in_tag, a_out_tag;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [7:0]  b_in_data, b_out_data;
  logic [2:0]  b_in_op;
  logic [2:0]  b_in_cnt;
  logic [3:0]  b_in_tag, b_out_tag;

  pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_op(a_in_op), .in_cnt(a_in_cnt), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .out_err(a_out_err)
  );

  pipelined_shifter #(.WIDTH(8), .STAGES(3), .TAG_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_op(b_in_op), .in_cnt(b_in_cnt), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .out_err(b_out_err)
  );

  typedef struct {
    logic [63:0] d;
    logic [3:0]  t;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          lat_a, lat_b;
  logic [63:0] a_exp_d, b_exp_d;
  logic        a_exp_e, b_exp_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Shift rules written straight from the operation definitions on a w-bit word.
  function automatic logic [63:0] ref_shift(input logic [63:0] x, input int op, input int c, input int w);
    logic [63:0] mask, r, xs;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xs = x & mask;
    case (op)
      0, 2: r = (xs << c) & mask;
      1:    r = xs >> c;
      3: begin
        r = xs >> c;
        if (((xs >> (w - 1)) & 64'd1) != 0) r = r | (mask & ~(mask >> c));
      end
      4:    r = (c == 0) ? xs : (((xs << c) | (xs >> (w - c))) & mask);
      5:    r = (c == 0) ? xs : (((xs >> c) | (xs << (w - c))) & mask);
      default: r = xs;
    endcase
    return r;
  endfunction

  task automatic cyc_a(output bit acc);
    exp_t e;
    #1;
    chk("a_in_ready_rule", 64'(a_in_ready), 64'(!(a_out_valid && !a_out_ready)));
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_spurious_out", 64'(a_out_valid), 64'd0);
      else begin
        e = qa.pop_front();
        chk("a_data", 64'(a_out_data), e.d);
        chk("a_tag", 64'(a_out_tag), 64'(e.t));
        chk("a_err", 64'(a_out_err), 64'(e.e));
        if (lat_a) chk("a_latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
    acc = a_in_valid && a_in_ready;
    if (acc) qa.push_back('{a_exp_d, a_in_tag, a_exp_e, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cyc_b(output bit acc);
    exp_t e;
    #1;
    chk("b_in_ready_rule", 64'(b_in_ready), 64'(!(b_out_valid && !b_out_ready)));
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_spurious_out", 64'(b_out_valid), 64'd0);
      else begin
        e = qb.pop_front();
        chk("b_data", 64'(b_out_data), e.d);
        chk("b_tag", 64'(b_out_tag), 64'(e.t));
        chk("b_err", 64'(b_out_err), 64'(e.e));
        if (lat_b) chk("b_latency", 64'(cyc - e.cyc), 64'd3);
      end
    end
    acc = b_in_valid && b_in_ready;
    if (acc) qb.push_back('{b_exp_d, b_in_tag, b_exp_e, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_a(input logic [2:0] op, input logic [4:0] cnt, input logic [31:0] data,
                        input logic [3:0] tag, input logic [63:0] exp_d, input logic exp_e, input bit rnd);
    bit acc;
    int n;
    a_in_valid = 1'b1; a_in_op = op; a_in_cnt = cnt; a_in_data = data; a_in_tag = tag;
    a_exp_d = exp_d; a_exp_e = exp_e;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      if (rnd) a_out_ready = ($urandom_range(0, 3) != 0);
      cyc_a(acc);
      n++;
    end
    if (!acc) chk("a_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_b(input logic [2:0] op, input logic [2:0] cnt, input logic [7:0] data,
                        input logic [3:0] tag, input logic [63:0] exp_d, input logic exp_e, input bit rnd);
    bit acc;
    int n;
    b_in_valid = 1'b1; b_in_op = op; b_in_cnt = cnt; b_in_data = data; b_in_tag = tag;
    b_exp_d = exp_d; b_exp_e = exp_e;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      if (rnd) b_out_ready = ($urandom_range(0, 3) != 0);
      cyc_b(acc);
      n++;
    end
    if (!acc) chk("b_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain_a();
    bit acc;
    int n;
    a_in_valid = 1'b0; a_out_ready = 1'b1; n = 0;
    while (qa.size() > 0 && n < 50) begin cyc_a(acc); n++; end
    chk("a_drain_empty", 64'(qa.size()), 64'd0);
    repeat (3) cyc_a(acc);
  endtask

  task automatic drain_b();
    bit acc;
    int n;
    b_in_valid = 1'b0; b_out_ready = 1'b1; n = 0;
    while (qb.size() > 0 && n < 50) begin cyc_b(acc); n++; end
    chk("b_drain_empty", 64'(qb.size()), 64'd0);
    repeat (3) cyc_b(acc);
  endtask

  initial begin
    bit          acc;
    logic [2:0]  op;
    logic [4:0]  ca;
    logic [2:0]  cb;
    logic [31:0] da;
    logic [7:0]  db;
    logic [3:0]  tg;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_op = '0; a_in_cnt = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_op = '0; b_in_cnt = '0; b_in_tag = '0; b_out_ready = 1'b1;
    lat_a = 1'b1; lat_b = 1'b1;
    a_exp_d = '0; a_exp_e = 1'b0; b_exp_d = '0; b_exp_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_out_data", 64'(a_out_data), 64'd0);
    chk("rst_a_out_tag", 64'(a_out_tag), 64'd0);
    chk("rst_a_out_err", 64'(a_out_err), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back rotate/shift vectors, two-cycle latency
    send_a(3'd4, 5'd1, 32'h80000001, 4'd1, 64'h00000003, 1'b0, 1'b0);
    send_a(3'd5, 5'd4, 32'h12345678, 4'd2, 64'h81234567, 1'b0, 1'b0);
    send_a(3'd3, 5'd4, 32'h80000000, 4'd3, 64'hF8000000, 1'b0, 1'b0);
    send_a(3'd1, 5'd4, 32'h80000000, 4'd4, 64'h08000000, 1'b0, 1'b0);
    drain_a();

    // Zero count leaves data unchanged. Illegal op passes data and flags an error.
    for (int o = 0; o < 6; o++)
      send_a(3'(o), 5'd0, 32'hDEADBEEF, 4'(o + 5), 64'hDEADBEEF, 1'b0, 1'b0);
    send_a(3'd7, 5'd5, 32'hDEADBEEF, 4'd11, 64'hDEADBEEF, 1'b1, 1'b0);
    drain_a();

    // Backpressure: the pipe fills and stays frozen for five cycles
    lat_a = 1'b0;
    a_out_ready = 1'b0;
    send_a(3'd0, 5'd1, 32'h00000001, 4'd5, 64'h00000002, 1'b0, 1'b0);
    send_a(3'd1, 5'd1, 32'h00000008, 4'd6, 64'h00000004, 1'b0, 1'b0);
    a_in_valid = 1'b1; a_in_op = 3'd4; a_in_cnt = 5'd8; a_in_data = 32'h000000FF; a_in_tag = 4'd7;
    a_exp_d = 64'h0000FF00; a_exp_e = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 64'(a_out_valid), 64'd1);
      chk("bp_in_ready", 64'(a_in_ready), 64'd0);
      chk("bp_out_tag_stable", 64'(a_out_tag), 64'd5);
      chk("bp_out_data_stable", 64'(a_out_data), 64'h2);
      cyc_a(acc);
      chk("bp_no_accept", 64'(acc), 64'd0);
    end
    a_out_ready = 1'b1;
    send_a(3'd4, 5'd8, 32'h000000FF, 4'd7, 64'h0000FF00, 1'b0, 1'b0);
    drain_a();

    // Reset mid-flight discards in-flight work
    send_a(3'd0, 5'd2, 32'h00000003, 4'd8, 64'h0000000C, 1'b0, 1'b0);
    send_a(3'd0, 5'd3, 32'h00000003, 4'd9, 64'h00000018, 1'b0, 1'b0);
    a_in_valid = 1'b0;
    chk("pre_rst_out_valid", 64'(a_out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("async_rst_out_data", 64'(a_out_data), 64'd0);
    chk("async_rst_out_tag", 64'(a_out_tag), 64'd0);
    chk("async_rst_in_ready", 64'(a_in_ready), 64'd1);
    #1 rst_n = 1'b1;
    qa.delete();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 5; i++) begin
      chk("rst_no_stale", 64'(a_out_valid), 64'd0);
      cyc_a(acc);
    end

    // Narrow configuration, three-cycle latency
    lat_b = 1'b1;
    send_b(3'd3, 3'd7, 8'h80, 4'd1, 64'hFF, 1'b0, 1'b0);
    send_b(3'd4, 3'd3, 8'h81, 4'd2, 64'h0C, 1'b0, 1'b0);
    send_b(3'd0, 3'd7, 8'hFF, 4'd3, 64'h80, 1'b0, 1'b0);
    drain_b();

    lat_b = 1'b0;
    for (int i = 0; i < 500; i++) begin
      op = 3'($urandom_range(0, 7)); cb = 3'($urandom); db = 8'($urandom); tg = 4'($urandom);
      send_b(op, cb, db, tg, ref_shift(64'(db), int'(op), int'(cb), 8), (op >= 3'd6), 1'b1);
    end
    drain_b();

    // Random traffic with random backpressure and idle gaps
    for (int i = 0; i < 10000; i++) begin
      op = 3'($urandom_range(0, 7)); ca = 5'($urandom); da = $urandom; tg = 4'($urandom);
      send_a(op, ca, da, tg, ref_shift(64'(da), int'(op), int'(ca), 32), (op >= 3'd6), 1'b1);
      if ($urandom_range(0, 7) == 0) begin
        a_in_valid = 1'b0;
        a_out_ready = ($urandom_range(0, 3) != 0);
        cyc_a(acc);
      end
    end
    drain_a();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
